hazard_hold_unit: RTL

- Stall and hold controller for the 5-stage LC-3b pipeline, directly upstream of the forwarding unit.
- Detects load-use hazards between IF/ID and ID/EX, and freezes the pipeline while the MEM stage waits on memory.
- Produces the 20-bit hold register (hold_reg_out) that the forwarding unit consumes as its third forwarding source, plus the stall1 freeze signal.

---
 rtl/lc3b_types.sv | 45 ++++
 rtl/hazard_wait_ctr.sv | 31 +++
 rtl/hazard_hold_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types used by the hazard/hold controller.
// Holds register, opcode and hold-register payload definitions.
package lc3b_types;

    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        logic     valid;
        lc3b_reg  dest;
        lc3b_word data;
    } lc3b_hold_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    localparam int unsigned HOLD_W = $bits(lc3b_hold_t);
    localparam int unsigned PERF_W = 32;

    function automatic logic is_load(input lc3b_opcode op);
        return (op == op_ldb) || (op == op_ldi) || (op == op_ldr);
    endfunction

endpackage

// File: rtl/hazard_wait_ctr.sv
// Saturating memory-wait counter; hit_c flags the increment that reaches THRESH.
module hazard_wait_ctr #(
    parameter int unsigned WAIT_CNT_W = 8,
    parameter int unsigned THRESH     = 200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic hit_c
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
    end

    assign hit_c = inc && (cnt_d >= WAIT_CNT_W'(THRESH));

    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hazard_hold_unit.sv
// Load-use stall / memory-wait freeze controller feeding the forwarding hold register.
// Optional HAZARD_PERF_EN adds lu_stall_cnt and mem_wait_cnt performance counters.
module hazard_hold_unit
    import lc3b_types::*;
#(
    parameter int unsigned WAIT_CNT_W   = 8,
    parameter int unsigned MAX_MEM_WAIT = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  lc3b_reg           ifid_src1,
    input  lc3b_reg           ifid_src2,
    input  logic              ifid_src1_vld,
    input  logic              ifid_src2_vld,
    input  lc3b_opcode        idex_opcode,
    input  lc3b_reg           idex_dest,
    input  logic              idex_ld_dest,
    input  logic              mem_stall,
    input  logic              mewb_ld_dest,
    input  lc3b_reg           destmux_out,
    input  lc3b_word          wb_data,
    input  logic              flush,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              stall1,
    output logic [HOLD_W-1:0] hold_reg_out,
`ifdef HAZARD_PERF_EN
    output logic [PERF_W-1:0] lu_stall_cnt,
    output logic [PERF_W-1:0] mem_wait_cnt,
`endif
    output logic              mem_timeout
);

    hazard_state_t state_q, state_d;
    lc3b_hold_t    hold_q, hold_d;
    logic          mem_timeout_q, mem_timeout_d;
    logic          src_hit, lu, lu_stall, idex_held;
    logic          ctr_inc, ctr_clr, ctr_hit;

    // Flush already kills the IF/ID instruction, so it suppresses the hazard.
    assign src_hit = (ifid_src1_vld && (ifid_src1 == idex_dest)) ||
                     (ifid_src2_vld && (ifid_src2 == idex_dest));
    assign lu      = is_load(idex_opcode) && idex_ld_dest && src_hit && !flush;

    always_comb begin
        state_d     = state_q;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        stall1      = 1'b0;
        lu_stall    = 1'b0;
        ctr_inc     = 1'b0;
        ctr_clr     = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    stall1     = 1'b1;
                    state_d    = MEM_WAIT;
                end else if (lu) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    lu_stall    = 1'b1;
                end else if (flush) begin
                    bubble_idex = 1'b1;
                end
            end
            MEM_WAIT: begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                stall1     = 1'b1;
                if (mem_stall) begin
                    ctr_inc = 1'b1;
                end else begin
                    ctr_clr = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Newest writeback wins while ID/EX is held; valid drops one cycle after release.
    assign idex_held = stall1 || ((state_q == RUN) && lu);

    always_comb begin
        hold_d        = hold_q;
        mem_timeout_d = mem_timeout_q || ctr_hit;
        if (idex_held) begin
            if (mewb_ld_dest) begin
                hold_d = '{valid: 1'b1, dest: destmux_out, data: wb_data};
            end
        end else begin
            hold_d.valid = 1'b0;
        end
    end

    hazard_wait_ctr #(
        .WAIT_CNT_W (WAIT_CNT_W),
        .THRESH     (MAX_MEM_WAIT)
    ) u_wait_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (ctr_inc),
        .clr     (ctr_clr),
        .hit_c   (ctr_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RUN;
            hold_q        <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign hold_reg_out = hold_q;
    assign mem_timeout  = mem_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] lu_stall_cnt_q, lu_stall_cnt_d;
    logic [PERF_W-1:0] mem_wait_cnt_q, mem_wait_cnt_d;

    always_comb begin
        lu_stall_cnt_d = lu_stall_cnt_q + PERF_W'(lu_stall);
        mem_wait_cnt_d = mem_wait_cnt_q + PERF_W'(state_q == MEM_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lu_stall_cnt_q <= '0;
            mem_wait_cnt_q <= '0;
        end else begin
            lu_stall_cnt_q <= lu_stall_cnt_d;
            mem_wait_cnt_q <= mem_wait_cnt_d;
        end
    end

    assign lu_stall_cnt = lu_stall_cnt_q;
    assign mem_wait_cnt = mem_wait_cnt_q;
`endif

endmodule
